// File: rtl/vx_mask_scanner_pkg.sv
// rtl/vx_mask_scanner_pkg.sv - scan-order selectors shared by the mask scanner and its index finder
package vx_mask_scanner_pkg;

  localparam int SCAN_LSB_FIRST = 0;
  localparam int SCAN_MSB_FIRST = 1;

endpackage

// File: rtl/vx_mask_scanner_lzc.sv
// rtl/vx_mask_scanner_lzc.sv - combinational index of the lowest (MODE 0) or highest (MODE 1) set bit
module vx_mask_scanner_lzc
  import vx_mask_scanner_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = SCAN_LSB_FIRST,
  localparam int LOGN = $clog2(N)
) (
  input  logic [N-1:0]    data_i,
  output logic [LOGN-1:0] idx_o,
  output logic            valid_o
);

  // Later loop iterations override earlier ones, so the loop direction sets the priority.
  always_comb begin
    idx_o = '0;
    if (MODE == SCAN_LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (data_i[i]) idx_o = LOGN'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (data_i[i]) idx_o = LOGN'(i);
      end
    end
  end

  assign valid_o = |data_i;

endmodule

// File: rtl/vx_mask_scanner.sv
// rtl/vx_mask_scanner.sv - serializes the set bits of a lane mask into one index per cycle on a valid/ready stream
module vx_mask_scanner
  import vx_mask_scanner_pkg::*;
#(
  parameter int N     = 8,
  parameter int MODE  = SCAN_LSB_FIRST,
  parameter int DATAW = 1,
  localparam int LOGN = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [N-1:0]     in_mask_i,
  input  logic [DATAW-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [LOGN-1:0]  out_idx_o,
  output logic [DATAW-1:0] out_data_o,
  output logic [LOGN-1:0]  out_pos_o,
  output logic             out_last_o,
  input  logic             out_ready_i
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     rem_mask_q, rem_mask_d;
  logic [DATAW-1:0] tag_q, tag_d;
  logic [LOGN-1:0]  pos_q, pos_d;

  logic [LOGN-1:0]  lzc_idx;
  logic             lzc_valid;
  logic             single_bit;
  logic             out_fire;
  logic             in_fire;

  vx_mask_scanner_lzc #(
    .N    (N),
    .MODE (MODE)
  ) u_lzc (
    .data_i  (rem_mask_q),
    .idx_o   (lzc_idx),
    .valid_o (lzc_valid)
  );

  assign single_bit  = (rem_mask_q & (rem_mask_q - N'(1))) == '0;

  assign out_valid_o = (state_q == BUSY);
  assign out_idx_o   = lzc_idx;
  assign out_data_o  = tag_q;
  assign out_pos_o   = pos_q;
  assign out_last_o  = out_valid_o && single_bit;

  assign out_fire    = out_valid_o && out_ready_i;
  // Accepting on the last handshake lets the next mask follow with no idle cycle.
  assign in_ready_o  = rst_ni && ((state_q == IDLE) || (out_fire && out_last_o));
  assign in_fire     = in_valid_i && in_ready_o;

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    tag_d      = tag_q;
    pos_d      = pos_q;

    if (out_fire) begin
      rem_mask_d = rem_mask_q & ~(N'(1) << lzc_idx);
      pos_d      = pos_q + LOGN'(1);
      if (out_last_o) state_d = IDLE;
    end

    if (in_fire) begin
      if (in_mask_i != '0) begin
        rem_mask_d = in_mask_i;
        tag_d      = in_data_i;
        pos_d      = '0;
        state_d    = BUSY;
      end else begin
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rem_mask_q <= '0;
      tag_q      <= '0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      tag_q      <= tag_d;
      pos_q      <= pos_d;
    end
  end

  // A BUSY scanner always holds at least one pending lane.
  busy_has_lane : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != BUSY) || lzc_valid);

endmodule

// File: tb/tb_vx_mask_scanner.sv
// tb/tb_vx_mask_scanner.sv - directed scoreboard bench driving LSB-first and MSB-first scanners in lockstep
module tb_vx_mask_scanner;

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] pos;
    logic       last;
    logic [3:0] data;
  } emit_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_mask = '0;
  logic [3:0] in_data = '0;
  logic       out_ready = 1'b1;

  logic       in_ready0, ov0, last0;
  logic [2:0] idx0, pos0;
  logic [3:0] data0;
  logic       in_ready1, ov1, last1;
  logic [2:0] idx1, pos1;
  logic [3:0] data1;

  emit_t q0[$];
  emit_t q1[$];
  logic  stall[2];
  emit_t held[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vx_mask_scanner #(.N(8), .MODE(0), .DATAW(4)) u_dut_lsb (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_mask_i(in_mask), .in_data_i(in_data), .in_ready_o(in_ready0),
    .out_valid_o(ov0), .out_idx_o(idx0), .out_data_o(data0), .out_pos_o(pos0),
    .out_last_o(last0), .out_ready_i(out_ready)
  );

  vx_mask_scanner #(.N(8), .MODE(1), .DATAW(4)) u_dut_msb (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_mask_i(in_mask), .in_data_i(in_data), .in_ready_o(in_ready1),
    .out_valid_o(ov1), .out_idx_o(idx1), .out_data_o(data1), .out_pos_o(pos1),
    .out_last_o(last1), .out_ready_i(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_expect(input logic [7:0] m, input logic [3:0] t);
    int k = 0;
    int n = 0;
    for (int i = 0; i < 8; i++) if (m[i]) n++;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        q0.push_back('{idx: 3'(i), pos: 3'(k), last: (k == n - 1), data: t});
        k++;
      end
    end
    k = 0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        q1.push_back('{idx: 3'(i), pos: 3'(k), last: (k == n - 1), data: t});
        k++;
      end
    end
  endfunction

  task automatic mon_one(input int which, input logic valid, input emit_t got);
    emit_t exp;
    if (stall[which]) begin
      tests++;
      assert (valid === 1'b1 && got === held[which]) else begin
        fails++;
        $error("FAIL hold%0d: observed valid=%0b %h expected valid=1 %h", which, valid, got, held[which]);
      end
    end
    if (valid && out_ready) begin
      tests++;
      assert ((which == 0 ? q0.size() : q1.size()) != 0) else begin
        fails++;
        $error("FAIL extra%0d: observed idx=%0d pos=%0d expected no output", which, got.idx, got.pos);
      end
      if ((which == 0 ? q0.size() : q1.size()) != 0) begin
        exp = (which == 0) ? q0.pop_front() : q1.pop_front();
        tests++;
        assert (got === exp) else begin
          fails++;
          $error("FAIL emit%0d: observed idx=%0d pos=%0d last=%0b data=%0d expected idx=%0d pos=%0d last=%0b data=%0d",
                 which, got.idx, got.pos, got.last, got.data, exp.idx, exp.pos, exp.last, exp.data);
        end
      end
    end
    stall[which] = valid && !out_ready;
    held[which]  = got;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      mon_one(0, ov0, '{idx: idx0, pos: pos0, last: last0, data: data0});
      mon_one(1, ov1, '{idx: idx1, pos: pos1, last: last1, data: data1});
    end
  end

  task automatic send(input logic [7:0] m, input logic [3:0] t, output int waited);
    in_valid = 1'b1;
    in_mask  = m;
    in_data  = t;
    push_expect(m, t);
    waited = 0;
    @(negedge clk);
    while (!in_ready0 && waited < 64) begin
      waited++;
      @(negedge clk);
    end
    chk("send_accept", waited < 64, 1);
    chk("in_ready_match", in_ready1, in_ready0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mask  = '0;
    in_data  = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || ov0 || ov1) && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n < 64, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int emitted;
    int cyc;
    stall[0] = 1'b0;
    stall[1] = 1'b0;

    #2;
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_idx", idx0, 0);
    chk("rst_out_data", data0, 0);
    chk("rst_out_pos", pos0, 0);
    chk("rst_out_last", last0, 0);
    chk("rst_in_ready", in_ready0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready0, 1);

    // 8'b1010_0100 tag 5: LSB-first 2,5,7 and MSB-first 7,5,2
    send(8'hA4, 4'd5, w);
    chk("a4_wait", w, 0);
    @(negedge clk);
    chk("a4_latency", ov0, 1);
    chk("a4_first_lsb", idx0, 2);
    chk("a4_first_msb", idx1, 7);
    @(posedge clk); #1;
    drain("a4_drain");
    chk("a4_idle_ready", in_ready0, 1);

    // backpressure pattern 1,0,0,1 on a full mask
    send(8'hFF, 4'd3, w);
    emitted = 0;
    cyc = 0;
    while (emitted < 8 && cyc < 64) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge clk);
      chk("bp_valid", ov0, 1);
      chk("bp_in_ready", in_ready0, out_ready && (emitted == 7));
      if (out_ready) emitted++;
      cyc++;
      @(posedge clk); #1;
    end
    chk("bp_done", emitted, 8);
    out_ready = 1'b1;
    drain("bp_drain");

    // back-to-back masks with continuous in_valid
    send(8'h81, 4'd3, w);
    send(8'h10, 4'd6, w);
    chk("b2b_wait", w, 1);
    @(negedge clk);
    chk("b2b_nobubble", ov0, 1);
    chk("b2b_idx", idx0, 4);
    chk("b2b_last", last0, 1);
    @(posedge clk); #1;
    drain("b2b_drain");

    // zero mask is swallowed in one cycle
    send(8'h00, 4'd1, w);
    chk("zero_wait", w, 0);
    @(negedge clk);
    chk("zero_no_out", ov0, 0);
    chk("zero_in_ready", in_ready0, 1);
    @(posedge clk); #1;
    send(8'h02, 4'd2, w);
    chk("after_zero_wait", w, 0);
    drain("zero_drain");

    // reset while scanning 8'hF0, after index 4 has been taken
    send(8'hF0, 4'd9, w);
    @(negedge clk);
    chk("mid_first_idx", idx0, 4);
    @(posedge clk); #1;
    q0.delete();
    q1.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_lsb", ov0, 0);
    chk("mid_rst_valid_msb", ov1, 0);
    chk("mid_rst_in_ready", in_ready0, 0);
    chk("mid_rst_pos", pos0, 0);
    chk("mid_rst_data", data0, 0);
    @(negedge clk);
    chk("mid_rst_hold_ready", in_ready0, 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", in_ready0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_residue", ov0 | ov1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
